// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU and the PI bridge,
// CPU first with a burst cap, and routes read results back to the issuing port.
module dmem_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              pi_req,
    input  logic              pi_we,
    input  logic [ADDR_W-1:0] pi_addr,
    input  logic [DATA_W-1:0] pi_wdata,
    output logic              pi_gnt,
    output logic              pi_rvalid,
    output logic [DATA_W-1:0] pi_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic [3:0]        burst_cnt;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_o;
    logic              cpu_win;
    logic              ret_v;
    logic              ret_o;
    always_comb begin
        cpu_win   = burst_cnt < 4'(MAX_BURST);
        cpu_gnt   = reset & cpu_req & (~pi_req | cpu_win);
        pi_gnt    = reset & pi_req & ~(cpu_req & cpu_win);
        mem_en    = cpu_gnt | pi_gnt;
        mem_we    = cpu_gnt ? cpu_we : (pi_gnt & pi_we);
        mem_addr  = cpu_gnt ? cpu_addr : pi_gnt ? pi_addr : '0;
        mem_wdata = cpu_gnt ? cpu_wdata : pi_gnt ? pi_wdata : '0;
        ret_v     = tag_v[RD_LAT-1];
        ret_o     = tag_o[RD_LAT-1];
    end
    // tag_o bit set = PI owns the read; the oldest tag lines up with mem_rdata
    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_cnt  <= '0;
            tag_v      <= '0;
            tag_o      <= '0;
            cpu_rvalid <= 1'b0;
            pi_rvalid  <= 1'b0;
            cpu_rdata  <= '0;
            pi_rdata   <= '0;
        end else begin
            burst_cnt  <= (!pi_req || pi_gnt) ? 4'd0 : burst_cnt + 4'(cpu_gnt);
            tag_v      <= (tag_v << 1) | RD_LAT'(mem_en & ~mem_we);
            tag_o      <= (tag_o << 1) | RD_LAT'(pi_gnt);
            cpu_rvalid <= ret_v & ~ret_o;
            pi_rvalid  <= ret_v & ret_o;
            if (ret_v && !ret_o)
                cpu_rdata <= mem_rdata;
            if (ret_v && ret_o)
                pi_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives RD_LAT=1 and RD_LAT=2 arbiters with identical traffic and checks
// both against a cycle-indexed scoreboard of expected grants and read returns.
module tb_dmem_arbiter;
    localparam int MB = 4;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, pi_req, pi_we;
    logic [12:0] cpu_addr, pi_addr;
    logic [15:0] cpu_wdata, pi_wdata;
    logic        cpu_gnt [2], pi_gnt [2], cpu_rvalid [2], pi_rvalid [2], mem_en [2], mem_we [2];
    logic [15:0] cpu_rdata [2], pi_rdata [2], mem_wdata [2], mem_rdata [2];
    logic [12:0] mem_addr [2];
    logic [15:0] mem [8192];
    logic [15:0] r1, r2a, r2b;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g
        dmem_arbiter #(.ADDR_W(13), .DATA_W(16), .MAX_BURST(MB), .RD_LAT(k + 1)) u (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
            .cpu_gnt(cpu_gnt[k]), .cpu_rvalid(cpu_rvalid[k]), .cpu_rdata(cpu_rdata[k]),
            .pi_req(pi_req), .pi_we(pi_we), .pi_addr(pi_addr), .pi_wdata(pi_wdata),
            .pi_gnt(pi_gnt[k]), .pi_rvalid(pi_rvalid[k]), .pi_rdata(pi_rdata[k]),
            .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
            .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k])
        );
    end

    // synchronous memory; the second instance sees one extra pipeline stage
    always @(posedge clk) begin
        if (mem_en[0] && mem_we[0]) mem[mem_addr[0]] <= mem_wdata[0];
        r1  <= mem[mem_addr[0]];
        r2a <= mem[mem_addr[1]];
        r2b <= r2a;
    end
    assign mem_rdata[0] = r1;
    assign mem_rdata[1] = r2b;

    int tests = 0, fails = 0, t = 0, bcnt = 0;
    bit started = 0, gc, gp, cpu_hold, pi_hold;
    bit ev_v [2][4096];
    bit ev_o [2][4096];
    logic [15:0] ev_d [2][4096];
    bit e_rv [2][2];
    logic [15:0] e_rd [2][2];
    logic [15:0] mm [8192];

    typedef struct { bit c; bit p; bit ec; bit ep; } vec_t;
    vec_t tab [19];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[u%0d] at cycle %0d: got %0h expected %0h", name, k, t, act, exp);
        end
    endtask

    task automatic pre();
        #1;
        gc = reset && cpu_req && (!pi_req || bcnt < MB);
        gp = reset && pi_req && !gc;
        for (int k = 0; k < 2; k++) begin
            chk("cpu_gnt", k, 32'(cpu_gnt[k]), 32'(gc));
            chk("pi_gnt", k, 32'(pi_gnt[k]), 32'(gp));
            chk("mem_en", k, 32'(mem_en[k]), 32'(gc | gp));
            chk("mem_we", k, 32'(mem_we[k]), 32'(gc ? cpu_we : gp ? pi_we : 1'b0));
            chk("mem_addr", k, 32'(mem_addr[k]), 32'(gc ? cpu_addr : gp ? pi_addr : 13'd0));
            chk("mem_wdata", k, 32'(mem_wdata[k]), 32'(gc ? cpu_wdata : gp ? pi_wdata : 16'd0));
            if (started) begin
                chk("cpu_rvalid", k, 32'(cpu_rvalid[k]), 32'(e_rv[k][0]));
                chk("pi_rvalid", k, 32'(pi_rvalid[k]), 32'(e_rv[k][1]));
                chk("cpu_rdata", k, 32'(cpu_rdata[k]), 32'(e_rd[k][0]));
                chk("pi_rdata", k, 32'(pi_rdata[k]), 32'(e_rd[k][1]));
            end
        end
    endtask

    task automatic post();
        for (int k = 0; k < 2; k++) begin
            e_rv[k][0] = 0;
            e_rv[k][1] = 0;
            if (!reset) begin
                e_rd[k][0] = '0;
                e_rd[k][1] = '0;
                for (int i = t + 1; i < t + 8; i++) ev_v[k][i] = 0;
            end else begin
                if (ev_v[k][t + 1]) begin
                    e_rv[k][ev_o[k][t + 1]] = 1;
                    e_rd[k][ev_o[k][t + 1]] = ev_d[k][t + 1];
                end
                if ((gc && !cpu_we) || (gp && !pi_we)) begin
                    ev_v[k][t + 2 + k] = 1;
                    ev_o[k][t + 2 + k] = gp;
                    ev_d[k][t + 2 + k] = mm[gc ? cpu_addr : pi_addr];
                end
            end
        end
        if (gc && cpu_we) mm[cpu_addr] = cpu_wdata;
        if (gp && pi_we) mm[pi_addr] = pi_wdata;
        bcnt = (!reset || !pi_req || gp) ? 0 : bcnt + (gc ? 1 : 0);
        if (!reset) started = 1;
        t++;
        @(negedge clk);
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    task automatic idle();
        cpu_req = 0; pi_req = 0; cpu_we = 0; pi_we = 0;
        cpu_addr = '0; pi_addr = '0; cpu_wdata = '0; pi_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) tab[i] = '{1, 1, (i % 5 != 4), (i % 5 == 4)};
        tab[10] = '{1, 1, 1, 0};
        tab[11] = '{1, 1, 1, 0};
        tab[12] = '{1, 0, 1, 0};
        for (int i = 13; i < 18; i++) tab[i] = '{1, 1, (i != 17), (i == 17)};
        tab[18] = '{0, 1, 0, 1};

        idle();
        reset = 0;
        cpu_req = 1; pi_req = 1; cpu_we = 1; pi_we = 1;
        for (int j = 0; j < 3; j++) begin
            pre();
            for (int k = 0; k < 2; k++) begin
                chk("rst_cpu_gnt", k, 32'(cpu_gnt[k]), 0);
                chk("rst_pi_gnt", k, 32'(pi_gnt[k]), 0);
                chk("rst_mem_en", k, 32'(mem_en[k]), 0);
                chk("rst_mem_we", k, 32'(mem_we[k]), 0);
                if (j > 0) begin
                    chk("rst_rvalid", k, 32'({cpu_rvalid[k], pi_rvalid[k]}), 0);
                    chk("rst_rdata", k, {cpu_rdata[k], pi_rdata[k]}, 0);
                end
            end
            post();
        end
        reset = 1;
        idle();
        // preload addresses 0..16 through the CPU port
        for (int a = 0; a <= 16; a++) begin
            cpu_req = 1; cpu_we = 1; cpu_addr = 13'(a);
            cpu_wdata = (a == 16) ? 16'hBEEF : 16'(a * 16'h1111);
            tick();
        end
        idle();

        cpu_req = 1; cpu_we = 1; cpu_addr = 13'd220; cpu_wdata = 16'h4060;
        pre();
        chk("wr_gnt", 0, 32'(cpu_gnt[0]), 1);
        chk("wr_mem_we", 0, 32'(mem_we[0]), 1);
        chk("wr_mem_addr", 0, 32'(mem_addr[0]), 220);
        chk("wr_mem_wdata", 0, 32'(mem_wdata[0]), 32'h4060);
        post();
        idle();
        for (int j = 0; j < 5; j++) begin
            pre();
            for (int k = 0; k < 2; k++) chk("wr_no_rvalid", k, 32'({cpu_rvalid[k], pi_rvalid[k]}), 0);
            post();
        end

        pi_req = 1; pi_we = 0; pi_addr = 13'h010;
        for (int j = 0; j < 4; j++) begin
            pre();
            if (j == 0) chk("pird_gnt", 0, 32'(pi_gnt[0]), 1);
            chk("pird_rvalid", 0, 32'(pi_rvalid[0]), 32'(j == 2));
            chk("pird_cpu_rvalid", 0, 32'(cpu_rvalid[0]), 0);
            if (j >= 2) chk("pird_rdata", 0, 32'(pi_rdata[0]), 32'hBEEF);
            post();
            idle();
        end
        tick();

        cpu_we = 1; pi_we = 1; cpu_addr = 13'd100; pi_addr = 13'd200;
        for (int i = 0; i < 19; i++) begin
            cpu_req = tab[i].c; pi_req = tab[i].p;
            cpu_wdata = 16'hC000 + 16'(i); pi_wdata = 16'hA000 + 16'(i);
            pre();
            for (int k = 0; k < 2; k++) begin
                chk("burst_cpu_gnt", k, 32'(cpu_gnt[k]), 32'(tab[i].ec));
                chk("burst_pi_gnt", k, 32'(pi_gnt[k]), 32'(tab[i].ep));
                chk("burst_addr", k, 32'(mem_addr[k]), tab[i].ec ? 100 : tab[i].ep ? 200 : 0);
            end
            post();
        end
        idle();
        tick();

        for (int j = 0; j < 7; j++) begin
            idle();
            if (j == 0) begin cpu_req = 1; cpu_addr = 13'd1; end
            if (j == 1) begin pi_req = 1; pi_addr = 13'd2; end
            if (j == 2) begin cpu_req = 1; cpu_addr = 13'd3; end
            pre();
            chk("il_cpu_rvalid", 1, 32'(cpu_rvalid[1]), 32'(j == 3 || j == 5));
            chk("il_pi_rvalid", 1, 32'(pi_rvalid[1]), 32'(j == 4));
            if (j == 3) chk("il_cpu_rdata0", 1, 32'(cpu_rdata[1]), 32'h1111);
            if (j == 4) chk("il_pi_rdata", 1, 32'(pi_rdata[1]), 32'h2222);
            if (j == 5) chk("il_cpu_rdata1", 1, 32'(cpu_rdata[1]), 32'h3333);
            post();
        end

        idle();
        cpu_req = 1; cpu_addr = 13'd1;
        tick();
        idle();
        reset = 0;
        tick();
        reset = 1;
        for (int j = 0; j < 6; j++) begin
            pre();
            for (int k = 0; k < 2; k++) begin
                chk("rstrd_rvalid", k, 32'(cpu_rvalid[k]), 0);
                chk("rstrd_rdata", k, 32'(cpu_rdata[k]), 0);
            end
            post();
        end

        cpu_hold = 0; pi_hold = 0;
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(99) != 0);
            if (!cpu_hold) begin
                cpu_req = ($urandom_range(9) < 6); cpu_we = 1'($urandom_range(1));
                cpu_addr = 13'($urandom_range(15)); cpu_wdata = 16'($urandom);
            end
            if (!pi_hold) begin
                pi_req = ($urandom_range(9) < 5); pi_we = 1'($urandom_range(1));
                pi_addr = 13'($urandom_range(15)); pi_wdata = 16'($urandom);
            end
            tick();
            cpu_hold = cpu_req && !gc;
            pi_hold = pi_req && !gp;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-port 16-bit data memory (13-bit word address) between the pipelined CPU data port and the Raspberry Pi GPIO bridge. It issues at most one memory access per cycle. The CPU has priority, but a burst limit guarantees the PI a slot. Read data is routed back to whichever requester issued the read.

Parameters:
ADDR_W, 13, memory address width
DATA_W, 16, memory data width
MAX_BURST, 4, max consecutive CPU grants while pi_req is pending (legal range 1..15)
RD_LAT, 1, memory read latency in cycles: mem_rdata is valid RD_LAT cycles after the issue cycle (legal range 1..4)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write enable (1 = write, 0 = read)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata holds a new read result
cpu_rdata  out  DATA_W  last CPU read result
pi_req, pi_we, pi_addr, pi_wdata, pi_gnt, pi_rvalid, pi_rdata  same as the cpu_* ports, for the PI bridge
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Handshake:
  - A transfer occurs in a cycle where req and gnt are both 1.
  - The requester holds we, addr and wdata stable while req=1 and gnt=0.
  - gnt is combinational from the req inputs and registered state, so a request is issued in the same cycle it is granted.
  - A requester may keep req=1 over consecutive cycles to issue back-to-back accesses.
- Memory port (combinational mux of the granted requester):
  - mem_en = cpu_gnt | pi_gnt.
  - mem_we = mem_en & we of the granted requester.
  - mem_addr and mem_wdata come from the granted requester.
  - When idle: mem_addr = 0 and mem_wdata = 0.
- Arbitration, with burst_cnt a 4-bit register:
  - Only cpu_req: grant CPU.
  - Only pi_req: grant PI.
  - Both, with burst_cnt < MAX_BURST: grant CPU and increment burst_cnt.
  - Both, with burst_cnt == MAX_BURST: grant PI.
  - burst_cnt clears to 0 on any PI grant, and in any cycle where pi_req = 0.
  - cpu_gnt and pi_gnt are never 1 together.
- Read return path:
  - A read issue pushes a tag {valid, owner} into a shift register of depth RD_LAT. Writes push valid = 0.
  - When the tag exits (cycle N+RD_LAT), mem_rdata is registered into the owner's rdata.
  - The owner's rvalid pulses for exactly one cycle at N+RD_LAT+1. Total read latency is RD_LAT+1 from the grant cycle.
  - rdata holds its value until the next read for that owner returns.
  - The other owner's rdata and rvalid are unaffected.
  - Back-to-back reads from either owner return in issue order at one result per cycle.
- Writes: no rvalid is generated. A write followed immediately by a read to the same address returns the new data; memory write-first ordering is guaranteed by issue order.
- Reset (reset = 0 at a rising edge):
  - Registered state: burst_cnt = 0, all tags cleared, cpu/pi_rvalid = 0, cpu/pi_rdata = 0.
  - While reset = 0, cpu_gnt = pi_gnt = 0 and mem_en = mem_we = 0 regardless of req.
  - Reset mid-operation discards outstanding reads; no rvalid is produced for them after reset is released.
  - The first grant is possible in the cycle after reset returns to 1.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with cpu_req = pi_req = 1 -> cpu_gnt, pi_gnt, mem_en, mem_we, rvalids all 0; rdatas = 0x0000.
2. CPU write: cpu_req=1, cpu_we=1, cpu_addr=220, cpu_wdata=0x4060 -> same cycle cpu_gnt=1, mem_we=1, mem_addr=220, mem_wdata=0x4060; no rvalid in the following 5 cycles.
3. PI read (RD_LAT=1): pi_req=1, pi_we=0, pi_addr=0x010 at cycle N; memory returns 0xBEEF at N+1 -> pi_gnt=1 at N; pi_rvalid=1 and pi_rdata=0xBEEF at N+2 only; cpu_rvalid stays 0.
4. Contention (MAX_BURST=4): cpu_req = pi_req = 1 for 10 cycles -> grant sequence C,C,C,C,P,C,C,C,C,P. Drop pi_req for one cycle mid-burst -> burst_cnt resets and the count restarts.
5. Interleaved reads (RD_LAT=2): CPU read addr 1, PI read addr 2, CPU read addr 3 on consecutive cycles, memory returning 0x1111/0x2222/0x3333 -> rvalid pulses at grant+3 route 0x1111 to CPU, 0x2222 to PI, 0x3333 to CPU, in order.
6. Reset mid-read: CPU read granted at cycle N, reset=0 at N+1 for one cycle -> no cpu_rvalid ever asserted for that read; cpu_rdata = 0x0000.
